// File: rtl/div_ctrl_if.sv
// Request/result and divider-core signals shared by div_ctrl and its environment.
// The master modport is the execute stage plus the divu core; the slave modport is div_ctrl.
interface div_ctrl_if;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [31:0] core_realb;
    logic        core_rst;
    logic [31:0] core_q;
    logic [31:0] core_r;
    logic        core_done;

    modport master (
        output start, is_signed, op_a, op_b, core_q, core_r, core_done,
        input  busy, done, div_zero, hi, lo, core_a, core_b, core_realb, core_rst
    );

    modport slave (
        input  start, is_signed, op_a, op_b, core_q, core_r, core_done,
        output busy, done, div_zero, hi, lo, core_a, core_b, core_realb, core_rst
    );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer in front of the iterative unsigned divider core: sign handling,
// divisor normalisation, core launch, sign correction and HI/LO write-back.
module div_ctrl (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, WAIT = 2'd2} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sa;
    logic        r_sb;
    logic [31:0] r_absa;
    logic [31:0] r_absb;
    logic [31:0] r_normb;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dz;
    logic        r_done;

    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_absa;
    logic [31:0] w_absb;
    logic [31:0] w_normb_sh;
    logic        w_can_shift;
    logic        w_zero;
    logic        w_load;

    function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign w_sa        = bus.is_signed & bus.op_a[31];
    assign w_sb        = bus.is_signed & bus.op_b[31];
    assign w_absa      = cond_neg(w_sa, bus.op_a);
    assign w_absb      = cond_neg(w_sb, bus.op_b);
    assign w_zero      = (bus.op_b == 32'd0);
    assign w_normb_sh  = {r_normb[30:0], 1'b0};
    // Stop before the top bit would be lost or the divisor would exceed the dividend.
    assign w_can_shift = ~r_normb[31] & (w_normb_sh <= r_absa);

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    if (!w_zero) w_next = NORM;
                end
            end
            NORM:    if (!w_can_shift) w_next = WAIT;
            WAIT:    if (bus.core_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_absa  <= 32'd0;
            r_absb  <= 32'd0;
            r_normb <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_sa    <= w_sa;
                r_sb    <= w_sb;
                r_absa  <= w_absa;
                r_absb  <= w_absb;
                r_normb <= w_absb;
                if (w_zero) begin
                    r_hi   <= bus.op_a;
                    r_lo   <= 32'hFFFF_FFFF;
                    r_dz   <= 1'b1;
                    r_done <= 1'b1;
                end
            end
            if (r_state == NORM && w_can_shift) r_normb <= w_normb_sh;
            // Quotient sign is the XOR of operand signs; remainder follows the dividend.
            if (r_state == WAIT && bus.core_done) begin
                r_lo   <= cond_neg(r_sa ^ r_sb, bus.core_q);
                r_hi   <= cond_neg(r_sa, bus.core_r);
                r_dz   <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign bus.busy       = (r_state != IDLE);
    assign bus.core_rst   = (r_state != WAIT);
    assign bus.core_a     = r_absa;
    assign bus.core_b     = r_normb;
    assign bus.core_realb = r_absb;
    assign bus.done       = r_done;
    assign bus.div_zero   = r_dz;
    assign bus.hi         = r_hi;
    assign bus.lo         = r_lo;
endmodule
